// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types, sizing constants and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [N_REQ-1:0] onehot_from_idx(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant and downstream valid/ready bundle between the requesters and the arbiter.
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] last;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
  logic             out_valid;
  logic             busy;

  modport master (
    output req, last, out_ready,
    input  sel, gnt, out_valid, busy
  );

  modport slave (
    input  req, last, out_ready,
    output sel, gnt, out_valid, busy
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating priority encoder: first set req bit strictly after ptr, wrapping back to ptr itself.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter driving the select of an 8:1 x 8-bit mux, with a valid/ready output.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux8_rr_arbiter_if.slave bus
);

  localparam int CNT_W = 4;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [SEL_W-1:0] pick_ptr, pick_idx;
  logic             pick_any;
  logic             req_sel, valid, beat, burst_end, rel_now;

  assign req_sel   = bus.req[sel_q];
  assign valid     = busy_q & req_sel;
  assign beat      = valid & bus.out_ready;
  assign burst_end = bus.last[sel_q] | (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign rel_now   = (beat & burst_end) | ~req_sel;

  // While granted, searching from sel gives the post-release pointer one cycle early.
  assign pick_ptr = (state_q == GRANT) ? sel_q : rr_ptr_q;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          sel_d      = pick_idx;
          gnt_d      = onehot_from_idx(pick_idx);
          busy_d     = 1'b1;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (beat) beat_cnt_d = beat_cnt_q + 1'b1;
        if (rel_now) begin
          rr_ptr_d   = sel_q;
          beat_cnt_d = '0;
          if (pick_any) begin
            sel_d = pick_idx;
            gnt_d = onehot_from_idx(pick_idx);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= SEL_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed and randomized checks of the round-robin burst arbiter against hand-derived expectations.
module tb_mux8_rr_arbiter;
  import mux8_arb_pkg::*;

  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic rdy);
    bus.req       = r;
    bus.last      = l;
    bus.out_ready = rdy;
    #1;
  endtask

  function automatic logic [12:0] obs();
    return {bus.busy, bus.out_valid, bus.sel, bus.gnt};
  endfunction

  function automatic logic [12:0] want(input logic b, input logic v, input logic [2:0] s,
                                       input logic [7:0] g);
    return {b, v, s, g};
  endfunction

  task automatic test_reset();
    logic [12:0] e;
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    tick();
    tick();
    e = want(1'b0, 1'b0, 3'd0, 8'h00);
    n_checks++;
    if (obs() !== e) $display("FAIL reset_state: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'hFF, 8'h00, 1'b1);
    tick();
    n_checks++;
    if (obs() !== e) $display("FAIL reset_dominates_req: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_g [0:8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
    logic [2:0]  exp_s [0:8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
    logic [12:0] e;
    drive(8'h81, 8'h00, 1'b1);
    n_checks++;
    if ({bus.busy, bus.out_valid, bus.gnt} !== 10'h000)
      $display("FAIL b2b_latency: got %h want 000", {bus.busy, bus.out_valid, bus.gnt});
    else n_pass++;
    tick();
    for (int c = 0; c < 9; c++) begin
      e = want(1'b1, 1'b1, exp_s[c], exp_g[c]);
      n_checks++;
      if (obs() !== e) $display("FAIL b2b_cycle%0d: got %h want %h", c, obs(), e);
      else n_pass++;
      if (c < 8) tick();
    end
    drive(8'h00, 8'h00, 1'b1);
    tick();
    n_checks++;
    if ({bus.busy, bus.out_valid, bus.gnt} !== 10'h000)
      $display("FAIL b2b_idle: got %h want 000", {bus.busy, bus.out_valid, bus.gnt});
    else n_pass++;
  endtask

  task automatic test_last_beat();
    logic [12:0] e;
    drive(8'h04, 8'h00, 1'b1);
    tick();
    e = want(1'b1, 1'b1, 3'd2, 8'h04);
    n_checks++;
    if (obs() !== e) $display("FAIL last_beat1: got %h want %h", obs(), e);
    else n_pass++;
    tick();
    // Requester 7 pending makes the early release visible as a grant move.
    drive(8'h84, 8'h04, 1'b1);
    n_checks++;
    if (obs() !== e) $display("FAIL last_beat2: got %h want %h", obs(), e);
    else n_pass++;
    tick();
    e = want(1'b1, 1'b1, 3'd7, 8'h80);
    n_checks++;
    if (obs() !== e) $display("FAIL last_release: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'h00, 8'h00, 1'b1);
    tick();
    n_checks++;
    if ({bus.busy, bus.out_valid, bus.gnt} !== 10'h000)
      $display("FAIL last_idle: got %h want 000", {bus.busy, bus.out_valid, bus.gnt});
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [12:0] e;
    drive(8'h08, 8'h00, 1'b0);
    tick();
    e = want(1'b1, 1'b1, 3'd3, 8'h08);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (obs() !== e) $display("FAIL stall_cycle%0d: got %h want %h", c, obs(), e);
      else n_pass++;
      tick();
    end
    drive(8'h18, 8'h08, 1'b1);
    n_checks++;
    if (obs() !== e) $display("FAIL stall_beat: got %h want %h", obs(), e);
    else n_pass++;
    tick();
    e = want(1'b1, 1'b1, 3'd4, 8'h10);
    n_checks++;
    if (obs() !== e) $display("FAIL stall_release: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'h00, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_withdraw();
    logic [12:0] e;
    drive(8'h20, 8'h00, 1'b0);
    tick();
    e = want(1'b1, 1'b1, 3'd5, 8'h20);
    n_checks++;
    if (obs() !== e) $display("FAIL wd_grant5: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'h40, 8'h00, 1'b0);
    e = want(1'b1, 1'b0, 3'd5, 8'h20);
    n_checks++;
    if (obs() !== e) $display("FAIL wd_valid_drop: got %h want %h", obs(), e);
    else n_pass++;
    tick();
    e = want(1'b1, 1'b1, 3'd6, 8'h40);
    n_checks++;
    if (obs() !== e) $display("FAIL wd_move6: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'h00, 8'h00, 1'b0);
    tick();
    n_checks++;
    if ({bus.busy, bus.out_valid, bus.gnt} !== 10'h000)
      $display("FAIL wd_idle: got %h want 000", {bus.busy, bus.out_valid, bus.gnt});
    else n_pass++;
    drive(8'h20, 8'h00, 1'b0);
    tick();
    drive(8'h00, 8'h00, 1'b0);
    tick();
    // Pointer now rests on 5, so 6 must beat 5 here.
    drive(8'h60, 8'h00, 1'b0);
    tick();
    e = want(1'b1, 1'b1, 3'd6, 8'h40);
    n_checks++;
    if (obs() !== e) $display("FAIL wd_ptr5: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'h00, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [12:0] e;
    drive(8'h04, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    e = want(1'b1, 1'b1, 3'd2, 8'h04);
    n_checks++;
    if (obs() !== e) $display("FAIL rmb_cnt2: got %h want %h", obs(), e);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    e = want(1'b0, 1'b0, 3'd0, 8'h00);
    n_checks++;
    if (obs() !== e) $display("FAIL rmb_abort: got %h want %h", obs(), e);
    else n_pass++;
    rst_n = 1'b1;
    drive(8'hFF, 8'h00, 1'b1);
    tick();
    e = want(1'b1, 1'b1, 3'd0, 8'h01);
    n_checks++;
    if (obs() !== e) $display("FAIL rmb_regrant0: got %h want %h", obs(), e);
    else n_pass++;
    drive(8'h00, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  r, l;
    logic        rdy, m_busy, found, beat, rel;
    logic [2:0]  m_sel, m_ptr, win;
    int          m_bcnt, worst;
    int          waits [8];
    logic [12:0] e, a;
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    tick();
    rst_n  = 1'b1;
    m_busy = 1'b0;
    m_sel  = 3'd0;
    m_ptr  = 3'd7;
    m_bcnt = 0;
    r      = 8'h00;
    foreach (waits[i]) waits[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      l   = 8'($urandom) & 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, l, rdy);
      e = want(m_busy, m_busy & r[m_sel], m_busy ? m_sel : 3'd0,
               m_busy ? (8'h01 << m_sel) : 8'h00);
      a = {bus.busy, bus.out_valid, m_busy ? bus.sel : 3'd0, bus.gnt};
      n_checks++;
      if (a !== e) $display("FAIL rand_cycle%0d: got %h want %h", cyc, a, e);
      else n_pass++;
      found = 1'b0;
      win   = 3'd0;
      rel   = !m_busy;
      if (m_busy) begin
        beat = r[m_sel] & rdy;
        if (beat) m_bcnt++;
        rel = (beat && (l[m_sel] || m_bcnt == MAX_BURST)) || !r[m_sel];
        if (rel) m_ptr = m_sel;
      end
      if (rel) begin
        for (int k = 1; k <= 8; k++) begin
          if (!found && r[(int'(m_ptr) + k) % 8]) begin
            found = 1'b1;
            win   = 3'((int'(m_ptr) + k) % 8);
          end
        end
        if (found) begin
          worst = 0;
          for (int b = 0; b < 8; b++) begin
            if (b == int'(win) || !r[b]) waits[b] = 0;
            else waits[b]++;
            if (waits[b] > worst) worst = waits[b];
          end
          n_checks++;
          if (worst > 7) $display("FAIL rand_fairness%0d: got %0d grants waited want <= 7", cyc, worst);
          else n_pass++;
        end
        m_busy = found;
        if (found) m_sel = win;
        m_bcnt = 0;
      end
      for (int b = 0; b < 8; b++) if (!r[b]) waits[b] = 0;
      tick();
    end
    drive(8'h00, 8'h00, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_last_beat();
    test_stall();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
